// File: rtl/decode_imm_stage_pkg.sv
// Shared decode constants: instruction/datapath widths, immediate formats,
// base opcodes and the decoded-entry record held by the decode skid buffer.
package decode_imm_stage_pkg;

    localparam int INSTR_LEN           = 32;
    localparam int XLEN                = 32;
    localparam int IMM_TYPE_BITS_COUNT = 3;

    typedef enum logic [IMM_TYPE_BITS_COUNT-1:0] {
        IMM_TYPE_I = 3'd0,
        IMM_TYPE_S = 3'd1,
        IMM_TYPE_B = 3'd2,
        IMM_TYPE_U = 3'd3,
        IMM_TYPE_J = 3'd4
    } imm_type_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
        logic [XLEN-1:0]      imm;
        imm_type_e            imm_type;
        logic                 has_imm;
        logic                 illegal;
    } decoded_entry_t;

    // Compressed encodings (low bits != 2'b11) are not supported by this stage.
    function automatic logic is_full_width(input logic [6:0] opcode);
        return opcode[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/decode_imm_stage_imm_decoder.sv
// Immediate decoder: rebuilds the I/S/B/U/J immediate from instr[31:7]
// and sign-extends it to XLEN.
module ImmDecoder
    import decode_imm_stage_pkg::*;
#(
    parameter int XLEN = decode_imm_stage_pkg::XLEN
) (
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (imm_type)
            IMM_TYPE_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_TYPE_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_TYPE_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
            IMM_TYPE_U: imm32 = {instr[31:12], 12'b0};
            IMM_TYPE_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
            default:    imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_imm_stage.sv
// Decode front end: classifies the opcode, decodes the immediate and holds
// decoded entries in a 2-entry skid buffer between fetch and execute.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
#(
    parameter int XLEN = decode_imm_stage_pkg::XLEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    input  logic [XLEN-1:0]                in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [XLEN-1:0]                out_pc,
    output logic [XLEN-1:0]                out_imm,
    output logic [IMM_TYPE_BITS_COUNT-1:0] out_imm_type,
    output logic                           out_has_imm,
    output logic                           out_illegal
);

    imm_type_e       cls_imm_type;
    logic            cls_has_imm;
    logic            cls_illegal;
    logic [XLEN-1:0] dec_imm;
    decoded_entry_t  new_entry;

    decoded_entry_t  main_d, main_q;
    decoded_entry_t  skid_d, skid_q;
    logic            main_valid_d, main_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic            accept;
    logic            pop;

    always_comb begin
        cls_imm_type = IMM_TYPE_I;
        cls_has_imm  = 1'b0;
        cls_illegal  = 1'b0;
        if (!is_full_width(in_instr[6:0])) begin
            cls_illegal = 1'b1;
        end else begin
            unique case (in_instr[6:0])
                OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR, OPCODE_SYSTEM: begin
                    cls_imm_type = IMM_TYPE_I;
                    cls_has_imm  = 1'b1;
                end
                OPCODE_STORE: begin
                    cls_imm_type = IMM_TYPE_S;
                    cls_has_imm  = 1'b1;
                end
                OPCODE_BRANCH: begin
                    cls_imm_type = IMM_TYPE_B;
                    cls_has_imm  = 1'b1;
                end
                OPCODE_LUI, OPCODE_AUIPC: begin
                    cls_imm_type = IMM_TYPE_U;
                    cls_has_imm  = 1'b1;
                end
                OPCODE_JAL: begin
                    cls_imm_type = IMM_TYPE_J;
                    cls_has_imm  = 1'b1;
                end
                OPCODE_OP: begin
                    cls_has_imm  = 1'b0;
                end
                default: begin
                    cls_illegal  = 1'b1;
                end
            endcase
        end
    end

    ImmDecoder #(
        .XLEN(XLEN)
    ) u_imm_decoder (
        .instr    (in_instr[31:7]),
        .imm_type (cls_imm_type),
        .imm      (dec_imm)
    );

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = in_pc;
        new_entry.instr    = in_instr;
        new_entry.imm      = cls_has_imm ? dec_imm : '0;
        new_entry.imm_type = cls_imm_type;
        new_entry.has_imm  = cls_has_imm;
        new_entry.illegal  = cls_illegal;
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q;
    assign pop      = main_valid_q && out_ready;

    // Skid is only ever occupied while main is occupied, so three states suffice.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid_q) begin
            if (pop && accept) begin
                main_d = new_entry;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end else if (pop) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_has_imm  = main_q.has_imm;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: directed scenarios plus randomized traffic,
// checked against a queue-based reference of the decode stage.
module tb_decode_imm_stage;
    import decode_imm_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [IMM_TYPE_BITS_COUNT-1:0] out_imm_type;
    logic        out_has_imm;
    logic        out_illegal;

    decode_imm_stage #(
        .XLEN(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_has_imm  (out_has_imm),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        has;
        logic        ill;
    } exp_t;

    exp_t        model_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference immediate built from field weights with signed integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   sx;
        int   top;
        sx    = $signed(w);
        top   = sx >>> 31;
        e.pc  = pc;
        e.instr = w;
        e.imm = '0;
        e.typ = IMM_TYPE_I;
        e.has = 1'b0;
        e.ill = 1'b0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                e.has = 1'b1;
                e.imm = sx >>> 20;
            end
            7'b0100011: begin
                e.has = 1'b1;
                e.typ = IMM_TYPE_S;
                e.imm = (sx >>> 25) * 32 + int'(w[11:7]);
            end
            7'b1100011: begin
                e.has = 1'b1;
                e.typ = IMM_TYPE_B;
                e.imm = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'b0110111, 7'b0010111: begin
                e.has = 1'b1;
                e.typ = IMM_TYPE_U;
                e.imm = w & 32'hFFFF_F000;
            end
            7'b1101111: begin
                e.has = 1'b1;
                e.typ = IMM_TYPE_J;
                e.imm = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            7'b0110011: begin
                e.has = 1'b0;
            end
            default: begin
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
        check_eq({tag, ".imm_known"}, 64'($isunknown(out_imm)), 64'd0);
        if (model_q.size() != 0) begin
            check_eq({tag, ".instr"}, 64'(out_instr), 64'(model_q[0].instr));
            check_eq({tag, ".pc"}, 64'(out_pc), 64'(model_q[0].pc));
            check_eq({tag, ".imm"}, 64'(out_imm), 64'(model_q[0].imm));
            check_eq({tag, ".has_imm"}, 64'(out_has_imm), 64'(model_q[0].has));
            check_eq({tag, ".illegal"}, 64'(out_illegal), 64'(model_q[0].ill));
            if (!model_q[0].ill)
                check_eq({tag, ".imm_type"}, 64'(out_imm_type), 64'(model_q[0].typ));
        end
    endtask

    // Called at a falling edge: check, drive, advance the model, move to next falling edge.
    task automatic step(input string tag, input logic v, input logic [31:0] instr,
                        input logic [31:0] pc, input logic ordy, input logic fl);
        logic acc;
        logic pp;
        check_outputs(tag);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = v && (model_q.size() < 2);
        pp  = (model_q.size() != 0) && ordy;
        if (fl) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(instr, pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        int unsigned k;
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        r = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) return {r[31:7], ops[k]};
        return r;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset.out_valid", 64'(out_valid), 64'd0);
        check_eq("reset.in_ready", 64'(in_ready), 64'd1);
        check_eq("reset.out_pc", 64'(out_pc), 64'd0);
        check_eq("reset.out_imm", 64'(out_imm), 64'd0);
        check_eq("reset.out_instr", 64'(out_instr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        step("addi", 1'b1, 32'hFFF0_0093, 32'h0000_1000, 1'b1, 1'b0);
        check_eq("addi.valid", 64'(out_valid), 64'd1);
        check_eq("addi.imm", 64'(out_imm), 64'hFFFF_FFFF);
        check_eq("addi.type", 64'(out_imm_type), 64'(IMM_TYPE_I));
        check_eq("addi.has", 64'(out_has_imm), 64'd1);
        check_eq("addi.ill", 64'(out_illegal), 64'd0);
        step("idle0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        step("sw", 1'b1, 32'hFE11_2E23, 32'h0000_2000, 1'b1, 1'b0);
        check_eq("sw.imm", 64'(out_imm), 64'hFFFF_FFFC);
        check_eq("sw.type", 64'(out_imm_type), 64'(IMM_TYPE_S));
        step("lui", 1'b1, 32'h1234_52B7, 32'h0000_2004, 1'b1, 1'b0);
        check_eq("lui.imm", 64'(out_imm), 64'h1234_5000);
        check_eq("lui.type", 64'(out_imm_type), 64'(IMM_TYPE_U));
        check_eq("lui.in_ready", 64'(in_ready), 64'd1);
        step("jal", 1'b1, 32'hFF9F_F06F, 32'h0000_2008, 1'b1, 1'b0);
        check_eq("jal.imm", 64'(out_imm), 64'hFFFF_FFF8);
        check_eq("jal.type", 64'(out_imm_type), 64'(IMM_TYPE_J));
        step("idle1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        step("stallA", 1'b1, 32'h0010_0093, 32'h0000_3000, 1'b0, 1'b0);
        step("stallB", 1'b1, 32'h0020_0113, 32'h0000_3004, 1'b0, 1'b0);
        check_eq("stall.in_ready_full", 64'(in_ready), 64'd0);
        step("stallC", 1'b1, 32'h0030_0193, 32'h0000_3008, 1'b0, 1'b0);
        check_eq("stall.hold_instr", 64'(out_instr), 64'h0010_0093);
        check_eq("stall.hold_imm", 64'(out_imm), 64'd1);
        step("drain0", 1'b1, 32'h0030_0193, 32'h0000_3008, 1'b1, 1'b0);
        check_eq("drain.second", 64'(out_instr), 64'h0020_0113);
        step("drain1", 1'b1, 32'h0030_0193, 32'h0000_3008, 1'b1, 1'b0);
        check_eq("drain.third", 64'(out_instr), 64'h0030_0193);
        step("drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        step("zero", 1'b1, 32'h0000_0000, 32'h0000_4000, 1'b1, 1'b0);
        check_eq("zero.ill", 64'(out_illegal), 64'd1);
        check_eq("zero.imm", 64'(out_imm), 64'd0);
        step("add", 1'b1, 32'h0000_0033, 32'h0000_4004, 1'b1, 1'b0);
        check_eq("add.ill", 64'(out_illegal), 64'd0);
        check_eq("add.has", 64'(out_has_imm), 64'd0);
        check_eq("add.imm", 64'(out_imm), 64'd0);
        step("idle2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        step("fillX", 1'b1, 32'h0050_0293, 32'h0000_5000, 1'b0, 1'b0);
        step("fillY", 1'b1, 32'h0060_0313, 32'h0000_5004, 1'b0, 1'b0);
        step("flushF", 1'b1, 32'h0070_0393, 32'h0000_5008, 1'b0, 1'b1);
        check_eq("flush.out_valid", 64'(out_valid), 64'd0);
        check_eq("flush.in_ready", 64'(in_ready), 64'd1);
        step("fillZ", 1'b1, 32'h0080_0413, 32'h0000_600C, 1'b0, 1'b0);
        step("flushHs", 1'b1, 32'h0090_0493, 32'h0000_6010, 1'b1, 1'b1);
        step("postflush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("flush.no_ghost", 64'(out_valid), 64'd0);

        step("fillP", 1'b1, 32'h00A0_0513, 32'h0000_7000, 1'b0, 1'b0);
        step("fillQ", 1'b1, 32'h00B0_0593, 32'h0000_7004, 1'b0, 1'b0);
        check_outputs("prereset");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.out_valid", 64'(out_valid), 64'd0);
        check_eq("arst.in_ready", 64'(in_ready), 64'd1);
        model_q.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 9) < 7), rand_instr(), $urandom(),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
